// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: drives SCK/SS_n and issues load, shift, sample and
// write-back strobes to an external shift register for one DWIDTH-bit transfer.
module spi_master_ctrl #(
  parameter int DWIDTH    = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 spif_clr,
  output logic                 SCK,
  output logic                 SS_n,
  output logic                 busy,
  output logic                 shifter_en,
  output logic                 Shift_en,
  output logic                 Sample_en,
  output logic                 SPDR_rd_en,
  output logic                 SPDR_wr_en,
  output logic                 SPIF
);

  localparam int EW = $clog2(2*DWIDTH+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DWIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, LEAD, XFER, TAIL, DONE} state_t;

  state_t               state;
  logic                 cpol_r, cpha_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [EW-1:0]        edge_cnt;

  logic          tc;
  logic [EW-1:0] next_edge;
  logic          leading;
  logic          edge_shift;
  logic          edge_sample;

  // Counter stops at div_r, so div_r = all-ones never wraps the counter.
  assign tc        = (div_cnt == div_r);
  assign next_edge = edge_cnt + 1'b1;
  assign leading   = next_edge[0];

  // Odd edges lead; with cpha=0 the final trailing edge carries no shift
  // because the MSB was already presented during LEAD.
  assign edge_shift  = cpha_r ? leading : (!leading && (next_edge != LAST_EDGE));
  assign edge_sample = cpha_r ? !leading : leading;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      SCK        <= 1'b0;
      SS_n       <= 1'b1;
      busy       <= 1'b0;
      shifter_en <= 1'b0;
      Shift_en   <= 1'b0;
      Sample_en  <= 1'b0;
      SPDR_rd_en <= 1'b0;
      SPDR_wr_en <= 1'b0;
      SPIF       <= 1'b0;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      div_r      <= '0;
      div_cnt    <= '0;
      edge_cnt   <= '0;
    end else begin
      shifter_en <= 1'b0;
      Shift_en   <= 1'b0;
      Sample_en  <= 1'b0;
      SPDR_rd_en <= 1'b0;
      SPDR_wr_en <= 1'b0;
      if (spif_clr) SPIF <= 1'b0;

      case (state)
        IDLE: begin
          SCK      <= cpol;
          SS_n     <= 1'b1;
          busy     <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (start) begin
            cpol_r     <= cpol;
            cpha_r     <= cpha;
            div_r      <= clk_div;
            state      <= LOAD;
            SPDR_rd_en <= 1'b1;
            busy       <= 1'b1;
            SS_n       <= 1'b0;
          end
        end

        LOAD: begin
          state <= LEAD;
          if (!cpha_r) begin
            Shift_en   <= 1'b1;
            shifter_en <= 1'b1;
          end
        end

        // LEAD is the half-period before edge 1; both share the edge generator.
        LEAD, XFER: begin
          if (tc) begin
            div_cnt <= '0;
            if (state == XFER && edge_cnt == LAST_EDGE) begin
              state <= TAIL;
            end else begin
              state      <= XFER;
              edge_cnt   <= next_edge;
              SCK        <= ~SCK;
              Shift_en   <= edge_shift;
              shifter_en <= edge_shift;
              Sample_en  <= edge_sample;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        TAIL: begin
          if (tc) begin
            div_cnt    <= '0;
            state      <= DONE;
            SPDR_wr_en <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          SS_n  <= 1'b1;
          SCK   <= cpol;
          SPIF  <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Sequencer for the SPI shift-register datapath in master mode.
- On a start request it loads SPDR into the shifter, asserts slave select and generates SCK at a programmable rate.
- Issues single-cycle sample/shift strobes per CPOL/CPHA, captures the received byte back into SPDR, and raises the sticky SPIF flag.
- Sits between the register interface (SPCR/SPSR/SPDR control) and the shifter/pads.

Parameters:
DWIDTH, 8, transfer length in bits (= shifter width)
DIV_WIDTH, 8, width of the SCK half-period divider field

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  transfer request; accepted only in IDLE
cpol  in  1  SCK idle level; latched on accept
cpha  in  1  0 = sample on leading edge, 1 = shift on leading edge; latched on accept
clk_div  in  DIV_WIDTH  SCK half-period = clk_div+1 clk cycles; latched on accept
spif_clr  in  1  clears SPIF
SCK  out  1  serial clock (registered)
SS_n  out  1  slave select, active-low (registered)
busy  out  1  high from LOAD through DONE
shifter_en  out  1  enables shifter output update; high for the cycle of every Shift_en pulse
Shift_en  out  1  1-cycle strobe: shifter presents next MSB on Data_out
Sample_en  out  1  1-cycle strobe: shifter captures Data_in
SPDR_rd_en  out  1  1-cycle strobe: load shifter from SPDR
SPDR_wr_en  out  1  1-cycle strobe: write received word to SPDR
SPIF  out  1  sticky transfer-complete flag

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; SCK=0, SS_n=1, busy=0, SPIF=0, all strobes 0, counters 0.
- Reset mid-transfer aborts within one cycle: no SPDR_wr_en, SPIF cleared.
- States: IDLE, LOAD, LEAD, XFER, TAIL, DONE.
- IDLE:
  - SCK follows cpol (registered, one cycle lag); SS_n=1; busy=0.
  - start=1 latches cpol/cpha/clk_div and goes to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle): SPDR_rd_en=1, busy=1, SS_n=0 → LEAD.
- LEAD (clk_div+1 cycles): SS_n=0, SCK=cpol.
  - If cpha=0, Shift_en=shifter_en=1 in the first LEAD cycle (presents MSB before the first edge).
  - On terminal count → XFER.
- XFER:
  - Half-period counter runs 0..clk_div; at terminal count SCK toggles and edge_cnt increments (1..2*DWIDTH).
  - Any strobe is asserted in the same cycle the new SCK level appears.
  - Odd edges are leading; even edges are trailing.
  - cpha=0: leading → Sample_en; trailing → Shift_en, except edge 2*DWIDTH, which gives no shift.
  - cpha=1: leading → Shift_en; trailing → Sample_en.
  - Exactly DWIDTH Sample_en pulses per transfer.
  - DWIDTH Shift_en pulses in total: cpha=0 counts the LEAD pulse.
  - After edge 2*DWIDTH, SCK=cpol → TAIL.
- TAIL (clk_div+1 cycles): SS_n=0, SCK=cpol → DONE.
- DONE (1 cycle): SPDR_wr_en=1, busy=1; SPIF sets on the next edge → IDLE, where SS_n=1.
- Total busy cycles = 2 + (2*DWIDTH+2)*(clk_div+1).
  - DWIDTH=8, clk_div=0 → 20.
  - clk_div=1 → 38.
- SPIF: set on DONE exit, cleared by spif_clr; simultaneous set and clear → set wins. SPIF does not block a new start.
- start held high continuously: next transfer begins one cycle after returning to IDLE (LOAD on the following cycle).
- Changes to cpol/cpha/clk_div during busy have no effect until the next accept.
- clk_div = all-ones: counter must not overflow; half-period = 2^DIV_WIDTH cycles.

Test Plan:
- Mode 0, clk_div=0, start pulse → busy high 20 cycles; SCK 8 rising edges, idle 0.
  - Sample_en on each rising edge; Shift_en in LEAD plus 7 falling edges.
  - SPDR_rd_en at cycle 1, SPDR_wr_en at cycle 20; SPIF=1 after.
- Mode 3 (cpol=1, cpha=1), clk_div=3 → SCK idle 1, half-period 4 cycles, busy 74 cycles.
  - Shift_en on falling (leading), Sample_en on rising (trailing), 8 each.
- Loopback with the shifter (Data_out→Data_in), SPDR_in=0xA5, all four modes → SPDR_out captured as 0xA5 on SPDR_wr_en.
- rst asserted at edge_cnt=5 → next cycle IDLE, SS_n=1, SCK=0, SPIF=0; no SPDR_wr_en.
- start pulsed while busy and cpol toggled mid-transfer → no restart; SCK level unaffected; one SPIF only.
- spif_clr asserted in DONE's following cycle together with the SPIF set → SPIF=1; spif_clr alone next cycle → SPIF=0.
